// File: rtl/dense_transpose_matvec_if.sv
// Bus bundle for dense_transpose_matvec: run/valid control, the vector input,
// the transposed-weight RAM read port and the result RAM write port.
interface dense_transpose_matvec_if #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DENSE_DATA_N = 8,
  parameter int HID_DIM      = 32,
  parameter int N_LEN        = 16
);
  logic                           run;
  logic                           valid;
  logic [HID_DIM*N_LEN-1:0]       vec;
  logic [ADDR_WIDTH-1:0]          raddr;
  logic [DENSE_DATA_N*N_LEN-1:0]  rdata;
  logic                           wen;
  logic [ADDR_WIDTH-1:0]          waddr;
  logic [DENSE_DATA_N*N_LEN-1:0]  wdata;

  modport master (
    output run, vec, rdata,
    input  valid, raddr, wen, waddr, wdata
  );

  modport slave (
    input  run, vec, rdata,
    output valid, raddr, wen, waddr, wdata
  );
endinterface

// File: rtl/dense_transpose_matvec.sv
// Streams the transposed weight RAM, computes out[c] = sum_h Wt[c][h]*vec[h]
// and writes saturated fixed-point results packed DENSE_DATA_N per word.
module dense_transpose_matvec #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DENSE_DATA_N = 8,
  parameter int FRAC_LEN     = 10,
  parameter int HID_DIM      = 32,
  parameter int CHAR_NUM     = 24,
  parameter int N_LEN        = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  dense_transpose_matvec_if.slave bus
);

  localparam int W         = HID_DIM / DENSE_DATA_N;
  localparam int R         = CHAR_NUM * W;
  localparam int W_BITS    = (W > 1) ? $clog2(W) : 1;
  localparam int LANE_BITS = (DENSE_DATA_N > 1) ? $clog2(DENSE_DATA_N) : 1;
  localparam int P_W       = 2 * N_LEN;
  localparam int ACC_W     = 2 * N_LEN + $clog2(HID_DIM);
  localparam int WORD_W    = DENSE_DATA_N * N_LEN;

  localparam logic [ADDR_WIDTH-1:0] R_LAST     = ADDR_WIDTH'(R - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WADDR = ADDR_WIDTH'(CHAR_NUM / DENSE_DATA_N - 1);
  localparam logic [W_BITS-1:0]     W_LAST     = W_BITS'(W - 1);
  localparam logic [LANE_BITS-1:0]  LANE_LAST  = LANE_BITS'(DENSE_DATA_N - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-N_LEN+1){1'b0}}, {(N_LEN-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-N_LEN+1){1'b1}}, {(N_LEN-1){1'b0}}};

  typedef enum logic {RD_ISSUE, RD_HOLD} rd_state_e;

  function automatic logic signed [P_W-1:0] mul_ext(input logic [N_LEN-1:0] a,
                                                    input logic [N_LEN-1:0] b);
    logic signed [P_W-1:0] ax;
    logic signed [P_W-1:0] bx;
    ax = {{N_LEN{a[N_LEN-1]}}, a};
    bx = {{N_LEN{b[N_LEN-1]}}, b};
    return ax * bx;
  endfunction

  rd_state_e              rd_state_q, rd_state_d;
  logic [ADDR_WIDTH-1:0]  raddr_q, raddr_d;
  logic [W_BITS-1:0]      col_q, col_d;
  logic [ADDR_WIDTH-1:0]  row_q, row_d;
  logic                   issue;

  logic                   v1_q, v1_d;
  logic [W_BITS-1:0]      col1_q, col1_d;
  logic [ADDR_WIDTH-1:0]  row1_q, row1_d;

  logic                   v2_q, v2_d, first2_q, first2_d, last2_q, last2_d;
  logic [ADDR_WIDTH-1:0]  row2_q, row2_d;
  logic signed [P_W-1:0]  prod_q [DENSE_DATA_N];
  logic signed [P_W-1:0]  prod_d [DENSE_DATA_N];

  logic                   v3_q, v3_d, first3_q, first3_d, last3_q, last3_d;
  logic [ADDR_WIDTH-1:0]  row3_q, row3_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;

  logic                   v4_q, v4_d, last4_q, last4_d;
  logic [ADDR_WIDTH-1:0]  row4_q, row4_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic signed [ACC_W-1:0] shifted, res;
  logic [WORD_W-1:0]      wbuf_q, wbuf_d;
  logic                   pend_q, pend_d;
  logic [ADDR_WIDTH-1:0]  pend_addr_q, pend_addr_d;

  logic                   wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
  logic [WORD_W-1:0]      wdata_q, wdata_d;
  logic                   done_flag_q, done_flag_d;

  // Read sequencer: one word per cycle until the last address, which is then held.
  always_comb begin
    rd_state_d = rd_state_q;
    raddr_d    = raddr_q;
    col_d      = col_q;
    row_d      = row_q;
    issue      = 1'b0;
    if (!bus.run) begin
      rd_state_d = RD_ISSUE;
      raddr_d    = '0;
      col_d      = '0;
      row_d      = '0;
    end else if (rd_state_q == RD_ISSUE) begin
      issue = 1'b1;
      if (raddr_q == R_LAST) begin
        rd_state_d = RD_HOLD;
      end else begin
        raddr_d = raddr_q + ADDR_WIDTH'(1);
        if (col_q == W_LAST) begin
          col_d = '0;
          row_d = row_q + ADDR_WIDTH'(1);
        end else begin
          col_d = col_q + W_BITS'(1);
        end
      end
    end
  end

  always_comb begin
    v1_d   = issue;
    col1_d = col_q;
    row1_d = row_q;

    v2_d     = v1_q;
    first2_d = (col1_q == '0);
    last2_d  = (col1_q == W_LAST);
    row2_d   = row1_q;
    for (int j = 0; j < DENSE_DATA_N; j++) begin
      prod_d[j] = mul_ext(bus.rdata[j*N_LEN +: N_LEN],
                          bus.vec[(int'(col1_q)*DENSE_DATA_N + j)*N_LEN +: N_LEN]);
    end

    v3_d     = v2_q;
    first3_d = first2_q;
    last3_d  = last2_q;
    row3_d   = row2_q;
    sum_d    = '0;
    for (int j = 0; j < DENSE_DATA_N; j++) begin
      sum_d = sum_d + {{(ACC_W-P_W){prod_q[j][P_W-1]}}, prod_q[j]};
    end

    v4_d    = v3_q;
    last4_d = last3_q;
    row4_d  = row3_q;
    acc_d   = acc_q;
    if (v3_q) begin
      acc_d = first3_q ? sum_q : acc_q + sum_q;
    end

    // Arithmetic shift floors toward minus infinity before clamping to N_LEN bits.
    shifted = acc_q >>> FRAC_LEN;
    if (shifted > SAT_MAX) begin
      res = SAT_MAX;
    end else if (shifted < SAT_MIN) begin
      res = SAT_MIN;
    end else begin
      res = shifted;
    end

    wbuf_d      = wbuf_q;
    pend_d      = 1'b0;
    pend_addr_d = pend_addr_q;
    if (v4_q && last4_q) begin
      for (int j = 0; j < DENSE_DATA_N; j++) begin
        if (row4_q[LANE_BITS-1:0] == LANE_BITS'(j)) begin
          wbuf_d[j*N_LEN +: N_LEN] = res[N_LEN-1:0];
        end
      end
      if (row4_q[LANE_BITS-1:0] == LANE_LAST) begin
        pend_d      = 1'b1;
        pend_addr_d = row4_q >> LANE_BITS;
      end
    end

    wen_d   = pend_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (pend_q) begin
      waddr_d = pend_addr_q;
      wdata_d = wbuf_q;
    end
    done_flag_d = done_flag_q | (wen_q && (waddr_q == LAST_WADDR));

    if (!bus.run) begin
      v1_d = 1'b0; col1_d = '0; row1_d = '0;
      v2_d = 1'b0; first2_d = 1'b0; last2_d = 1'b0; row2_d = '0;
      for (int j = 0; j < DENSE_DATA_N; j++) prod_d[j] = '0;
      v3_d = 1'b0; first3_d = 1'b0; last3_d = 1'b0; row3_d = '0; sum_d = '0;
      v4_d = 1'b0; last4_d = 1'b0; row4_d = '0; acc_d = '0;
      wbuf_d = '0; pend_d = 1'b0; pend_addr_d = '0;
      wen_d = 1'b0; waddr_d = '0; wdata_d = '0; done_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_ISSUE;
      raddr_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      v1_q <= 1'b0; col1_q <= '0; row1_q <= '0;
      v2_q <= 1'b0; first2_q <= 1'b0; last2_q <= 1'b0; row2_q <= '0;
      for (int j = 0; j < DENSE_DATA_N; j++) prod_q[j] <= '0;
      v3_q <= 1'b0; first3_q <= 1'b0; last3_q <= 1'b0; row3_q <= '0; sum_q <= '0;
      v4_q <= 1'b0; last4_q <= 1'b0; row4_q <= '0; acc_q <= '0;
      wbuf_q <= '0; pend_q <= 1'b0; pend_addr_q <= '0;
      wen_q <= 1'b0; waddr_q <= '0; wdata_q <= '0; done_flag_q <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      raddr_q    <= raddr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      v1_q <= v1_d; col1_q <= col1_d; row1_q <= row1_d;
      v2_q <= v2_d; first2_q <= first2_d; last2_q <= last2_d; row2_q <= row2_d;
      for (int j = 0; j < DENSE_DATA_N; j++) prod_q[j] <= prod_d[j];
      v3_q <= v3_d; first3_q <= first3_d; last3_q <= last3_d; row3_q <= row3_d; sum_q <= sum_d;
      v4_q <= v4_d; last4_q <= last4_d; row4_q <= row4_d; acc_q <= acc_d;
      wbuf_q <= wbuf_d; pend_q <= pend_d; pend_addr_q <= pend_addr_d;
      wen_q <= wen_d; waddr_q <= waddr_d; wdata_q <= wdata_d; done_flag_q <= done_flag_d;
    end
  end

  assign bus.raddr = raddr_q;
  assign bus.wen   = wen_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
  assign bus.valid = bus.run & done_flag_q;

endmodule

// File: tb/tb_dense_transpose_matvec.sv
// Scoreboard bench for dense_transpose_matvec: a behavioural RAM feeds the DUT,
// a reference model queues expected writes, and a monitor checks each strobe.
module tb_dense_transpose_matvec;

  localparam int AW     = 10;
  localparam int DN     = 8;
  localparam int FL     = 10;
  localparam int HD     = 32;
  localparam int CN     = 24;
  localparam int NL     = 16;
  localparam int W      = HD / DN;
  localparam int R      = CN * W;
  localparam int WORD_W = DN * NL;
  localparam int NWR    = CN / DN;

  typedef struct {
    logic [AW-1:0]     addr;
    logic [WORD_W-1:0] data;
  } wr_t;

  logic clk;
  logic rst_n;

  dense_transpose_matvec_if #(.ADDR_WIDTH(AW), .DENSE_DATA_N(DN), .HID_DIM(HD), .N_LEN(NL)) bus ();

  dense_transpose_matvec #(
    .ADDR_WIDTH(AW), .DENSE_DATA_N(DN), .FRAC_LEN(FL),
    .HID_DIM(HD), .CHAR_NUM(CN), .N_LEN(NL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WORD_W-1:0]    mem [R];
  logic signed [NL-1:0] wt [CN][HD];
  logic signed [NL-1:0] vecv [HD];
  wr_t expQ[$];
  wr_t monExp;
  int passCount  = 0;
  int checkCount = 0;
  int writeCount = 0;

  // Behavioural weight RAM with one cycle of read latency.
  always @(posedge clk) bus.rdata <= mem[int'(bus.raddr)];

  task automatic checkOutput(input string tag, input logic [WORD_W-1:0] observed,
                             input logic [WORD_W-1:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  // Every write strobe is matched against the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && bus.wen) begin
      writeCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_wen", WORD_W'(bus.wen), WORD_W'(0));
      end else begin
        monExp = expQ.pop_front();
        checkOutput("waddr", WORD_W'(bus.waddr), WORD_W'(monExp.addr));
        checkOutput("wdata", bus.wdata, monExp.data);
      end
    end
  end

  // Loads weights and vector for a pattern and queues the expected writes.
  task automatic applyStimulus(input int pattern);
    logic [WORD_W-1:0] word;
    longint acc;
    longint q;
    for (int h = 0; h < HD; h++) begin
      case (pattern)
        1:       vecv[h] = 16'(h <<< FL);
        2:       vecv[h] = 16'sh0400;
        3:       vecv[h] = 16'sh7FFF;
        4:       vecv[h] = 16'sh8001;
        default: vecv[h] = 16'sh0300;
      endcase
      bus.vec[h*NL +: NL] = vecv[h];
    end
    for (int c = 0; c < CN; c++) begin
      for (int h = 0; h < HD; h++) begin
        case (pattern)
          1:       wt[c][h] = (h == c % HD) ? 16'sh0400 : 16'sh0000;
          2:       wt[c][h] = 16'sh0200;
          3, 4:    wt[c][h] = 16'sh7FFF;
          default: wt[c][h] = (h == (c * 5) % HD) ? ((c % 2 == 0) ? 16'shFC00 : 16'shFFFF)
                                                  : 16'sh0000;
        endcase
      end
      for (int w = 0; w < W; w++) begin
        for (int j = 0; j < DN; j++) word[j*NL +: NL] = wt[c][w*DN + j];
        mem[c*W + w] = word;
      end
    end
    for (int a = 0; a < NWR; a++) begin
      for (int j = 0; j < DN; j++) begin
        acc = 0;
        for (int h = 0; h < HD; h++) acc += longint'(wt[a*DN + j][h]) * longint'(vecv[h]);
        q = acc >>> FL;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        word[j*NL +: NL] = 16'(q);
      end
      expQ.push_back('{addr: AW'(a), data: word});
    end
  endtask

  task automatic prepareRun(input int pattern);
    expQ.delete();
    writeCount = 0;
    applyStimulus(pattern);
  endtask

  // Counts edges from run rising (just before edge 0) until valid, then checks completion.
  task automatic finishRun(input bit checkTiming);
    int n;
    n = 0;
    while (bus.valid !== 1'b1 && n < 400) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checkOutput("valid_seen", WORD_W'(bus.valid), WORD_W'(1));
    if (checkTiming) checkOutput("valid_latency", WORD_W'(n - 1), WORD_W'(R + 5));
    repeat (10) @(negedge clk);
    checkOutput("write_count", WORD_W'(writeCount), WORD_W'(NWR));
    checkOutput("queue_left", WORD_W'(expQ.size()), WORD_W'(0));
    checkOutput("valid_hold", WORD_W'(bus.valid), WORD_W'(1));
    bus.run = 1'b0;
    @(negedge clk);
    checkOutput("valid_low", WORD_W'(bus.valid), WORD_W'(0));
    @(negedge clk);
  endtask

  task automatic doRun(input int pattern, input bit checkTiming);
    prepareRun(pattern);
    @(negedge clk);
    bus.run = 1'b1;
    finishRun(checkTiming);
  endtask

  task automatic waitRaddr(input int target);
    int n;
    n = 0;
    while (int'(bus.raddr) != target && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_raddr", WORD_W'(bus.raddr), WORD_W'(target));
  endtask

  initial begin
    for (int r = 0; r < R; r++) mem[r] = '0;
    rst_n   = 1'b0;
    bus.run = 1'b0;
    bus.vec = '0;
    #12;
    checkOutput("rst_raddr", WORD_W'(bus.raddr), WORD_W'(0));
    checkOutput("rst_wen",   WORD_W'(bus.wen),   WORD_W'(0));
    checkOutput("rst_waddr", WORD_W'(bus.waddr), WORD_W'(0));
    checkOutput("rst_wdata", bus.wdata,          WORD_W'(0));
    checkOutput("rst_valid", WORD_W'(bus.valid), WORD_W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] identity weights");
    doRun(1, 1'b1);
    $display("[TB] uniform half weights");
    doRun(2, 1'b1);
    $display("[TB] positive and negative saturation");
    doRun(3, 1'b0);
    doRun(4, 1'b0);
    $display("[TB] negative results and floor rounding");
    doRun(5, 1'b0);

    $display("[TB] abort mid-run");
    prepareRun(1);
    @(negedge clk);
    bus.run = 1'b1;
    waitRaddr(R / 2);
    bus.run = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_wen",   WORD_W'(bus.wen),   WORD_W'(0));
      checkOutput("abort_raddr", WORD_W'(bus.raddr), WORD_W'(0));
    end
    doRun(1, 1'b1);

    $display("[TB] async reset mid-run");
    prepareRun(1);
    @(negedge clk);
    bus.run = 1'b1;
    waitRaddr(90);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_raddr", WORD_W'(bus.raddr), WORD_W'(0));
    checkOutput("arst_wen",   WORD_W'(bus.wen),   WORD_W'(0));
    checkOutput("arst_waddr", WORD_W'(bus.waddr), WORD_W'(0));
    checkOutput("arst_wdata", bus.wdata,          WORD_W'(0));
    checkOutput("arst_valid", WORD_W'(bus.valid), WORD_W'(0));
    prepareRun(1);
    @(negedge clk);
    rst_n = 1'b1;
    finishRun(1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
